uart_rx_multi: RTL and testbench

//  Parametrised UART receiver: configurable data width, parity mode, stop bits and oversample ratio.

---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart_rx_sampler.sv | 56 +++++
 rtl/uart_rx_multi.sv | 192 +++++++++++++++++++
 tb/tb_uart_rx_multi.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and sizing helpers for the parametrised UART receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_BREAK
  } state_e;

  localparam int unsigned PARITY_NONE = 0;
  localparam int unsigned PARITY_ODD  = 1;
  localparam int unsigned PARITY_EVEN = 2;

  // Bits needed to count 0..n-1.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// rx synchroniser plus three-point majority vote around the middle of each bit.
module uart_rx_sampler
  import uart_pkg::*;
#(
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned CNT_W      = cnt_width(OVERSAMPLE)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             rx,
  input  logic [CNT_W-1:0] cnt,
  output logic             rxs,
  output logic             bit_val,
  output logic             bit_strobe
);

  localparam int unsigned      M      = OVERSAMPLE / 2;
  localparam logic [CNT_W-1:0] CNT_S0 = CNT_W'(M - 1);
  localparam logic [CNT_W-1:0] CNT_S1 = CNT_W'(M);
  localparam logic [CNT_W-1:0] CNT_S2 = CNT_W'(M + 1);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic s0_q, s0_d;
  logic s1_q, s1_d;

  always_comb begin
    sync1_d = rx;
    sync2_d = sync1_q;
    s0_d    = s0_q;
    s1_d    = s1_q;
    if (tick && (cnt == CNT_S0)) s0_d = sync2_q;
    if (tick && (cnt == CNT_S1)) s1_d = sync2_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      s0_q    <= 1'b1;
      s1_q    <= 1'b1;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      s0_q    <= s0_d;
      s1_q    <= s1_d;
    end
  end

  // Third sample is the live synchronised value on the deciding tick.
  assign rxs        = sync2_q;
  assign bit_strobe = tick && (cnt == CNT_S2);
  assign bit_val    = (s0_q & s1_q) | (s0_q & sync2_q) | (s1_q & sync2_q);

endmodule

// File: rtl/uart_rx_multi.sv
// UART receiver: tick-driven oversampling FSM, parity/framing checks and a
// one-entry valid/ready holding register with overrun reporting.
module uart_rx_multi
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned PARITY     = 0,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tick,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  input  logic                 ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int unsigned      CNT_W     = cnt_width(OVERSAMPLE);
  localparam int unsigned      IDX_W     = cnt_width(DATA_BITS);
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(OVERSAMPLE - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);
  localparam logic             STOP_LAST = 1'(STOP_BITS - 1);
  localparam logic             PAR_ODD   = (PARITY == PARITY_ODD);

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic                 stop_q, stop_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;
  logic                 done_c;

  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 parity_err_q, parity_err_d;
  logic                 frame_err_q, frame_err_d;
  logic                 overrun_q, overrun_d;
  logic                 busy_q, busy_d;
  logic                 pop_c;

  logic rxs, bit_val, bit_strobe;

  uart_rx_sampler #(
    .OVERSAMPLE (OVERSAMPLE),
    .CNT_W      (CNT_W)
  ) u_sampler (
    .clk        (clk),
    .rst        (rst),
    .tick       (tick),
    .rx         (rx),
    .cnt        (cnt_q),
    .rxs        (rxs),
    .bit_val    (bit_val),
    .bit_strobe (bit_strobe)
  );

  // Frame FSM; everything advances on tick only.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    stop_d  = stop_q;
    perr_d  = perr_q;
    ferr_d  = ferr_q;
    done_c  = 1'b0;
    if (tick) begin
      cnt_d = (cnt_q == CNT_MAX) ? '0 : cnt_q + 1'b1;
      unique case (state_q)
        ST_IDLE: begin
          cnt_d = '0;
          if (!rxs) begin
            state_d = ST_START;
            stop_d  = 1'b0;
            perr_d  = 1'b0;
            ferr_d  = 1'b0;
          end
        end
        ST_START: begin
          if (bit_strobe) begin
            if (bit_val) begin
              state_d = ST_IDLE;
              cnt_d   = '0;
            end else begin
              state_d = ST_DATA;
              idx_d   = '0;
            end
          end
        end
        ST_DATA: begin
          if (bit_strobe) begin
            shift_d = {bit_val, shift_q[DATA_BITS-1:1]};
            idx_d   = idx_q + 1'b1;
            if (idx_q == IDX_LAST) state_d = (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
          end
        end
        ST_PARITY: begin
          if (bit_strobe) begin
            perr_d  = ((^shift_q) ^ bit_val) != PAR_ODD;
            state_d = ST_STOP;
          end
        end
        ST_STOP: begin
          if (bit_strobe) begin
            ferr_d = ferr_q | ~bit_val;
            stop_d = stop_q + 1'b1;
            // Leave at mid-stop so a back-to-back start edge is not missed.
            if (stop_q == STOP_LAST) begin
              done_c  = 1'b1;
              cnt_d   = '0;
              state_d = (ferr_d && (shift_q == '0)) ? ST_BREAK : ST_IDLE;
            end
          end
        end
        ST_BREAK: begin
          cnt_d = '0;
          if (rxs) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Holding register: load when empty or popped this clk, otherwise flag overrun.
  always_comb begin
    data_d       = data_q;
    valid_d      = valid_q;
    parity_err_d = parity_err_q;
    frame_err_d  = frame_err_q;
    overrun_d    = 1'b0;
    pop_c        = valid_q && ready;
    busy_d       = (state_d != ST_IDLE);
    if (pop_c) valid_d = 1'b0;
    if (done_c) begin
      if (!valid_q || pop_c) begin
        data_d       = shift_q;
        parity_err_d = perr_q;
        frame_err_d  = ferr_d;
        valid_d      = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      shift_q      <= '0;
      idx_q        <= '0;
      stop_q       <= 1'b0;
      perr_q       <= 1'b0;
      ferr_q       <= 1'b0;
      data_q       <= '0;
      valid_q      <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      shift_q      <= shift_d;
      idx_q        <= idx_d;
      stop_q       <= stop_d;
      perr_q       <= perr_d;
      ferr_q       <= ferr_d;
      data_q       <= data_d;
      valid_q      <= valid_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
      overrun_q    <= overrun_d;
      busy_q       <= busy_d;
    end
  end

  assign data       = data_q;
  assign valid      = valid_q;
  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;
  assign overrun    = overrun_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_uart_rx_multi.sv
// Bench for uart_rx_multi: three configurations (8N1, 8E1, 7O2) driven by table
// vectors, hand-written corner sequences and random frames against a frame model.
module tb_uart_rx_multi;

  localparam int OS = 16;

  typedef struct packed {
    logic [8:0] data;
    logic       pe;
    logic       fe;
  } rec_t;

  typedef struct {
    int         d;
    logic [8:0] dat;
    logic       pbit;
    logic [1:0] stops;
    logic [8:0] exp_data;
    logic       exp_pe;
    logic       exp_fe;
  } vec_t;

  logic       clk;
  logic       rst;
  logic       tick;
  logic [2:0] rx_l;
  logic [2:0] ready_l;
  logic [2:0] valid_w, pe_w, fe_w, ov_w, busy_w;
  logic [7:0] data0, data1;
  logic [6:0] data2;
  logic [8:0] data_w [3];

  int cfg_bits [3] = '{8, 8, 7};
  int cfg_par  [3] = '{0, 2, 1};
  int cfg_stop [3] = '{1, 1, 2};

  int n_checks = 0;
  int n_pass   = 0;
  int tick_period = 1;
  int cyc = 0;
  int tick_cnt = 0;

  rec_t got_q [3][$];
  rec_t prev_rec [3];
  logic [2:0] prev_valid = '0;
  int vrise [3] = '{0, 0, 0};
  int ov_cnt [3] = '{0, 0, 0};

  uart_rx_multi #(.DATA_BITS(8), .OVERSAMPLE(OS), .PARITY(0), .STOP_BITS(1)) u_8n1 (
    .clk(clk), .rst(rst), .tick(tick), .rx(rx_l[0]), .data(data0), .valid(valid_w[0]),
    .ready(ready_l[0]), .parity_err(pe_w[0]), .frame_err(fe_w[0]), .overrun(ov_w[0]),
    .busy(busy_w[0]));

  uart_rx_multi #(.DATA_BITS(8), .OVERSAMPLE(OS), .PARITY(2), .STOP_BITS(1)) u_8e1 (
    .clk(clk), .rst(rst), .tick(tick), .rx(rx_l[1]), .data(data1), .valid(valid_w[1]),
    .ready(ready_l[1]), .parity_err(pe_w[1]), .frame_err(fe_w[1]), .overrun(ov_w[1]),
    .busy(busy_w[1]));

  uart_rx_multi #(.DATA_BITS(7), .OVERSAMPLE(OS), .PARITY(1), .STOP_BITS(2)) u_7o2 (
    .clk(clk), .rst(rst), .tick(tick), .rx(rx_l[2]), .data(data2), .valid(valid_w[2]),
    .ready(ready_l[2]), .parity_err(pe_w[2]), .frame_err(fe_w[2]), .overrun(ov_w[2]),
    .busy(busy_w[2]));

  assign data_w[0] = {1'b0, data0};
  assign data_w[1] = {1'b0, data1};
  assign data_w[2] = {2'b00, data2};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    tick = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      tick = ((cyc % tick_period) == 0);
    end
  end

  always @(posedge clk) if (tick) tick_cnt <= tick_cnt + 1;

  // Record each accepted frame (valid && ready at an edge) and count events.
  always begin
    @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      if (prev_valid[d] && ready_l[d] && !rst) got_q[d].push_back(prev_rec[d]);
      if (valid_w[d] && !prev_valid[d]) vrise[d]++;
      if (ov_w[d]) ov_cnt[d]++;
      prev_valid[d] = valid_w[d];
      prev_rec[d]   = '{data: data_w[d], pe: pe_w[d], fe: fe_w[d]};
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
  endtask

  // Frame expectation computed from the line-level bits.
  function automatic rec_t model(input int d, input logic [8:0] dat, input logic pbit,
                                 input logic [1:0] stops);
    rec_t r;
    int   ones;
    r = '0;
    for (int i = 0; i < cfg_bits[d]; i++) r.data[i] = dat[i];
    ones = $countones(r.data) + int'(pbit);
    if (cfg_par[d] == 1) r.pe = ((ones % 2) == 0);
    else if (cfg_par[d] == 2) r.pe = ((ones % 2) == 1);
    r.fe = !stops[0] || ((cfg_stop[d] == 2) && !stops[1]);
    return r;
  endfunction

  task automatic drive(input int d, input logic lvl, input int n);
    int target;
    rx_l[d] = lvl;
    target  = tick_cnt + n;
    while (tick_cnt < target) @(negedge clk);
  endtask

  task automatic send_frame(input int d, input logic [8:0] dat, input logic pbit,
                            input logic [1:0] stops, input int glitch, input int idle);
    drive(d, 1'b0, OS);
    for (int i = 0; i < cfg_bits[d]; i++) begin
      if (i == glitch) begin
        drive(d, dat[i], 8);
        drive(d, ~dat[i], 1);
        drive(d, dat[i], OS - 9);
      end else begin
        drive(d, dat[i], OS);
      end
    end
    if (cfg_par[d] != 0) drive(d, pbit, OS);
    for (int s = 0; s < cfg_stop[d]; s++) drive(d, stops[s], OS);
    if (idle > 0) drive(d, 1'b1, idle);
  endtask

  task automatic expect_frame(input int d, input rec_t e, input string name);
    int waited;
    waited = 0;
    while ((got_q[d].size() == 0) && (waited < 2000)) begin
      @(negedge clk);
      waited++;
    end
    if (got_q[d].size() == 0) begin
      n_checks++;
      $display("FAIL %s: no frame delivered, expected 0x%0h", name, e);
    end else begin
      check(name, 32'(got_q[d].pop_front()), 32'(e));
    end
  endtask

  task automatic reset_mid_data(input string tag);
    int v0;
    ready_l[0] = 1'b0;
    send_frame(0, 9'h033, 1'b0, 2'b11, -1, 2 * OS);
    check({tag, "_held"}, 32'(valid_w[0]), 32'd1);
    drive(0, 1'b0, OS);
    drive(0, 1'b1, OS);
    drive(0, 1'b0, OS);
    drive(0, 1'b1, OS / 2);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check({tag, "_rst_busy"}, 32'(busy_w[0]), 32'd0);
    check({tag, "_rst_valid"}, 32'(valid_w[0]), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    v0 = vrise[0];
    ready_l[0] = 1'b1;
    drive(0, 1'b1, 2 * OS);
    check({tag, "_no_partial"}, 32'(vrise[0] - v0), 32'd0);
    send_frame(0, 9'h05A, 1'b0, 2'b11, -1, 2 * OS);
    expect_frame(0, model(0, 9'h05A, 1'b0, 2'b11), {tag, "_5a"});
  endtask

  vec_t vecs [9];

  initial begin
    int   v0;
    int   ov0;
    int   d;
    logic [8:0] dat;
    logic pbit;
    logic [1:0] stops;
    int   glitch;
    rec_t e;

    vecs[0] = '{0, 9'h0A5, 1'b0, 2'b11, 9'h0A5, 1'b0, 1'b0};
    vecs[1] = '{1, 9'h003, 1'b1, 2'b11, 9'h003, 1'b1, 1'b0};
    vecs[2] = '{1, 9'h003, 1'b0, 2'b11, 9'h003, 1'b0, 1'b0};
    vecs[3] = '{2, 9'h041, 1'b1, 2'b01, 9'h041, 1'b0, 1'b1};
    vecs[4] = '{0, 9'h0FF, 1'b0, 2'b10, 9'h0FF, 1'b0, 1'b1};
    vecs[5] = '{1, 9'h080, 1'b1, 2'b11, 9'h080, 1'b0, 1'b0};
    vecs[6] = '{2, 9'h07F, 1'b0, 2'b11, 9'h07F, 1'b0, 1'b0};
    vecs[7] = '{2, 9'h07F, 1'b1, 2'b11, 9'h07F, 1'b1, 1'b0};
    vecs[8] = '{0, 9'h000, 1'b0, 2'b11, 9'h000, 1'b0, 1'b0};

    rst = 1'b1;
    rx_l = 3'b111;
    ready_l = 3'b111;
    repeat (4) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("reset_state_%0d", i),
            32'({valid_w[i], busy_w[i], pe_w[i], fe_w[i], ov_w[i], data_w[i]}), 32'd0);
    end
    rst = 1'b0;
    drive(0, 1'b1, 2 * OS);

    for (int i = 0; i < 9; i++) begin
      send_frame(vecs[i].d, vecs[i].dat, vecs[i].pbit, vecs[i].stops, -1, 2 * OS);
      expect_frame(vecs[i].d, '{data: vecs[i].exp_data, pe: vecs[i].exp_pe, fe: vecs[i].exp_fe},
                   $sformatf("vec%0d", i));
    end

    // Framing error followed by a long low line: one all-zero frame, then BREAK.
    v0 = vrise[2];
    send_frame(2, 9'h041, 1'b1, 2'b01, -1, 0);
    drive(2, 1'b0, 30 * OS);
    check("break_busy", 32'(busy_w[2]), 32'd1);
    drive(2, 1'b1, 2 * OS);
    check("break_exit_busy", 32'(busy_w[2]), 32'd0);
    expect_frame(2, '{data: 9'h041, pe: 1'b0, fe: 1'b1}, "break_first");
    expect_frame(2, '{data: 9'h000, pe: 1'b1, fe: 1'b1}, "break_zero_frame");
    drive(2, 1'b1, 4 * OS);
    check("break_valid_count", 32'(vrise[2] - v0), 32'd2);

    // Short low pulse is rejected as a glitch.
    v0 = vrise[0];
    drive(0, 1'b0, 5);
    drive(0, 1'b1, 3 * OS);
    check("short_pulse_busy", 32'(busy_w[0]), 32'd0);
    check("short_pulse_no_valid", 32'(vrise[0] - v0), 32'd0);

    send_frame(1, 9'h05C, 1'b0, 2'b11, 3, 2 * OS);
    expect_frame(1, model(1, 9'h05C, 1'b0, 2'b11), "glitch_5c");

    // Overrun: second frame dropped while the first is held.
    ready_l[0] = 1'b0;
    ov0 = ov_cnt[0];
    send_frame(0, 9'h011, 1'b0, 2'b11, -1, OS);
    send_frame(0, 9'h022, 1'b0, 2'b11, -1, 2 * OS);
    check("ovr_valid_held", 32'(valid_w[0]), 32'd1);
    check("ovr_data_held", 32'(data_w[0]), 32'h11);
    check("ovr_pulse_count", 32'(ov_cnt[0] - ov0), 32'd1);
    ready_l[0] = 1'b1;
    expect_frame(0, model(0, 9'h011, 1'b0, 2'b11), "ovr_pop_11");
    repeat (2) @(negedge clk);
    check("ovr_valid_clear", 32'(valid_w[0]), 32'd0);
    check("ovr_dropped", 32'(got_q[0].size()), 32'd0);

    reset_mid_data("rst_t1");
    tick_period = 4;
    reset_mid_data("rst_t4");

    for (int i = 0; i < 30; i++) begin
      tick_period = $urandom_range(1, 3);
      d      = $urandom_range(0, 2);
      dat    = 9'($urandom);
      pbit   = 1'($urandom);
      stops  = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b11;
      glitch = ($urandom_range(0, 1) == 0) ? -1 : $urandom_range(0, 6);
      e = model(d, dat, pbit, stops);
      send_frame(d, dat, pbit, stops, glitch, 2 * OS);
      expect_frame(d, e, $sformatf("rand%0d_d%0d", i, d));
    end

    check("ovr_total_8n1", 32'(ov_cnt[0]), 32'd1);
    check("ovr_total_8e1", 32'(ov_cnt[1]), 32'd0);
    check("ovr_total_7o2", 32'(ov_cnt[2]), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
